// File: rtl/r4u5_bf1_sdf.sv
// Radix-2^2 SDF first butterfly (BF_I) of FFT unit 5 on a block-floating-point stream.
// Pairs each sample with the one D earlier: emits sums (k1=0), then the stored differences (k1=1).
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

module r4u5_bf1_sdf #(
    parameter int DEPTH_MAX = 256
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic                  block_sync_i,
    input  logic                  stage_sync_i,
    input  logic                  data_val_i,
    input  logic [`MAN_WIDTH-1:0] data_real_i,
    input  logic [`MAN_WIDTH-1:0] data_imag_i,
    input  logic [`EXP_WIDTH-1:0] data_exp_i,
    input  logic [3:0]            ldn_rg_i,
    output logic                  block_sync_o,
    output logic                  next_sync_o,
    output logic                  data_val_o,
    output logic [`MAN_WIDTH-1:0] data_real_o,
    output logic [`MAN_WIDTH-1:0] data_imag_o,
    output logic [`EXP_WIDTH-1:0] data_exp_o,
    output logic                  k1_o
);
    localparam int W  = `MAN_WIDTH;
    localparam int EW = `EXP_WIDTH;
    localparam int MW = 2 * W + EW;
    localparam int AW = $clog2(DEPTH_MAX);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_BFLY   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam logic signed [W:0] MAX_P  = (W+1)'((2 ** (W - 1)) - 1);
    localparam logic [EW:0]       SH_LIM = (EW+1)'(W);
    localparam logic [EW:0]       SH_ONE = (EW+1)'(1);
    localparam logic [CW-1:0]     D_FULL = CW'(DEPTH_MAX);
    localparam logic [CW-1:0]     D_HALF = CW'(DEPTH_MAX / 2);
    localparam logic [CW-1:0]     C_ONE  = CW'(1);

    // Arithmetic right shift with round-half-away-from-zero; shifts of W or more give 0.
    function automatic logic signed [W:0] sym_shr(input logic signed [W:0] v, input logic [EW:0] sh);
        logic signed [W+1:0] ext;
        logic [W+1:0]        mag;
        logic [W+1:0]        rnd;
        logic signed [W:0]   res;
        ext = {v[W], v};
        mag = v[W] ? $unsigned(-ext) : $unsigned(ext);
        rnd = '0;
        if (sh == '0) begin
            res = v;
        end else begin
            if (sh < SH_LIM)
                rnd = (mag + ({{(W+1){1'b0}}, 1'b1} << (sh - SH_ONE))) >> sh;
            res = v[W] ? -$signed(rnd[W:0]) : $signed(rnd[W:0]);
        end
        return res;
    endfunction

    // Exponent-aligned add/sub of a (older sample) and x, renormalised by one bit on overflow.
    function automatic logic [MW-1:0] bf_op(input logic [MW-1:0] a, input logic [MW-1:0] x,
                                            input logic sub);
        logic signed [W-1:0]  ar, ai, xr, xi;
        logic signed [EW-1:0] ae, xe, e;
        logic signed [EW:0]   ed;
        logic [EW:0]          d;
        logic signed [W:0]    sar, sai, sxr, sxi, rr, ri;
        {ar, ai, ae} = a;
        {xr, xi, xe} = x;
        ed  = {ae[EW-1], ae} - {xe[EW-1], xe};
        d   = ed[EW] ? $unsigned(-ed) : $unsigned(ed);
        e   = ed[EW] ? xe : ae;
        sar = {ar[W-1], ar};
        sai = {ai[W-1], ai};
        sxr = {xr[W-1], xr};
        sxi = {xi[W-1], xi};
        if (ed[EW]) begin
            sar = sym_shr(sar, d);
            sai = sym_shr(sai, d);
        end else begin
            sxr = sym_shr(sxr, d);
            sxi = sym_shr(sxi, d);
        end
        rr = sub ? sar - sxr : sar + sxr;
        ri = sub ? sai - sxi : sai + sxi;
        if (rr > MAX_P || rr < -MAX_P || ri > MAX_P || ri < -MAX_P) begin
            rr = sym_shr(rr, SH_ONE);
            ri = sym_shr(ri, SH_ONE);
            e  = e + {{(EW-1){1'b0}}, 1'b1};
        end
        return {rr[W-1:0], ri[W-1:0], e};
    endfunction

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_d;
    logic          r_blk;
    logic          r_val, r_k1, r_ns, r_bs;
    logic [MW-1:0] r_odata;
    logic [MW-1:0] r_mem [DEPTH_MAX];

    logic          w_sync;
    logic [2:0]    w_mode;
    logic [CW-1:0] w_cnt, w_d, w_dm1, w_d2m1;
    logic [AW-1:0] w_addr;
    logic [MW-1:0] w_x, w_rd, w_sum, w_dif;
    logic [2:0]    w_nstate;
    logic [CW-1:0] w_ncnt;
    logic          w_we;
    logic [MW-1:0] w_wdata;
    logic          w_oval, w_ok1, w_ons;
    logic [MW-1:0] w_odata;

    // A synced sample restarts the frame at cnt 0; after a sum half it is a REFILL entry.
    assign w_sync = stage_sync_i & data_val_i;
    assign w_mode = !w_sync ? r_state :
                    (r_state == S_DRAIN || r_state == S_REFILL) ? S_REFILL : S_FILL;
    assign w_cnt  = w_sync ? '0 : r_cnt;
    assign w_d    = !w_sync ? r_d : (ldn_rg_i == 4'd10) ? D_HALF : D_FULL;
    assign w_dm1  = w_d - C_ONE;
    assign w_d2m1 = (w_d << 1) - C_ONE;
    assign w_addr = AW'(w_cnt & w_dm1);
    assign w_x    = {data_real_i, data_imag_i, data_exp_i};
    assign w_rd   = r_mem[w_addr];
    assign w_sum  = bf_op(w_rd, w_x, 1'b0);
    assign w_dif  = bf_op(w_rd, w_x, 1'b1);

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_we     = 1'b0;
        w_wdata  = w_x;
        w_oval   = 1'b0;
        w_ok1    = 1'b0;
        w_ons    = 1'b0;
        w_odata  = '0;
        case (w_mode)
            S_FILL, S_REFILL: begin
                if (data_val_i) begin
                    w_we     = 1'b1;
                    w_ncnt   = w_cnt + C_ONE;
                    w_nstate = (w_cnt == w_dm1) ? S_BFLY : w_mode;
                    if (w_mode == S_REFILL) begin
                        w_oval  = 1'b1;
                        w_ok1   = 1'b1;
                        w_odata = w_rd;
                    end
                end
            end
            S_BFLY: begin
                if (data_val_i) begin
                    w_we    = 1'b1;
                    w_wdata = w_dif;
                    w_oval  = 1'b1;
                    w_odata = w_sum;
                    w_ons   = (w_cnt == w_d);
                    if (w_cnt == w_d2m1) begin
                        w_nstate = S_DRAIN;
                        w_ncnt   = '0;
                    end else begin
                        w_ncnt = w_cnt + C_ONE;
                    end
                end
            end
            S_DRAIN: begin
                // Drains one stored difference per cycle regardless of input valid.
                w_oval  = 1'b1;
                w_ok1   = 1'b1;
                w_odata = w_rd;
                if (w_cnt == w_dm1) begin
                    w_nstate = S_IDLE;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = w_cnt + C_ONE;
                end
            end
            default: w_nstate = r_state;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_blk   <= 1'b0;
            r_val   <= 1'b0;
            r_k1    <= 1'b0;
            r_ns    <= 1'b0;
            r_bs    <= 1'b0;
            r_odata <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_d     <= w_d;
            r_blk   <= w_sync ? block_sync_i : r_blk;
            r_val   <= w_oval;
            r_k1    <= w_ok1;
            r_ns    <= w_ons;
            r_bs    <= w_ons & r_blk;
            r_odata <= w_odata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_we)
            r_mem[w_addr] <= w_wdata;
    end

    assign data_val_o   = r_val;
    assign k1_o         = r_k1;
    assign next_sync_o  = r_ns;
    assign block_sync_o = r_bs;
    assign {data_real_o, data_imag_o, data_exp_o} = r_odata;

endmodule

// File: tb/tb_r4u5_bf1_sdf.sv
// Randomised scoreboard bench for r4u5_bf1_sdf: driver pushes expected outputs from an
// integer reference of the butterfly, a negedge monitor pops and compares them.
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

module tb_r4u5_bf1_sdf;
    localparam int W    = `MAN_WIDTH;
    localparam int EW   = `EXP_WIDTH;
    localparam int OW   = 3 + 2 * W + EW;
    localparam int MAXP = (1 << (W - 1)) - 1;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic          block_sync_i = 1'b0;
    logic          stage_sync_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [W-1:0]  data_real_i = '0;
    logic [W-1:0]  data_imag_i = '0;
    logic [EW-1:0] data_exp_i = '0;
    logic [3:0]    ldn_rg_i = 4'd11;
    logic          block_sync_o, next_sync_o, data_val_o, k1_o;
    logic [W-1:0]  data_real_o, data_imag_o;
    logic [EW-1:0] data_exp_o;

    r4u5_bf1_sdf #(.DEPTH_MAX(256)) dut (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .block_sync_i(block_sync_i),
        .stage_sync_i(stage_sync_i),
        .data_val_i  (data_val_i),
        .data_real_i (data_real_i),
        .data_imag_i (data_imag_i),
        .data_exp_i  (data_exp_i),
        .ldn_rg_i    (ldn_rg_i),
        .block_sync_o(block_sync_o),
        .next_sync_o (next_sync_o),
        .data_val_o  (data_val_o),
        .data_real_o (data_real_o),
        .data_imag_o (data_imag_o),
        .data_exp_o  (data_exp_o),
        .k1_o        (k1_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    initial begin
        #5ms;
        $display("FAIL watchdog: run still active at 5ms, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            cont_mode = 1'b0;
    bit            cont_seen = 1'b0;
    int            fr_re[512];
    int            fr_im[512];
    int            fr_e[512];

    // ---------------- reference model ----------------
    function automatic int rnd_shift(input int v, input int sh);
        int mag, q;
        if (sh >= W) return 0;
        mag = (v < 0) ? -v : v;
        q   = (mag + (2 ** sh) / 2) / (2 ** sh);
        return (v < 0) ? -q : q;
    endfunction

    function automatic logic [OW-1:0] ref_bf(input int ar, input int ai, input int ae,
                                             input int xr, input int xi, input int xe,
                                             input bit sub, input bit k1, input bit ns, input bit bs);
        int e, r, i;
        if (ae >= xe) begin
            e  = ae;
            xr = rnd_shift(xr, ae - xe);
            xi = rnd_shift(xi, ae - xe);
        end else begin
            e  = xe;
            ar = rnd_shift(ar, xe - ae);
            ai = rnd_shift(ai, xe - ae);
        end
        r = sub ? ar - xr : ar + xr;
        i = sub ? ai - xi : ai + xi;
        if (r > MAXP || r < -MAXP || i > MAXP || i < -MAXP) begin
            e = e + 1;
            r = rnd_shift(r, 1);
            i = rnd_shift(i, 1);
        end
        return {ns, bs, k1, W'(r), W'(i), EW'(e)};
    endfunction

    function automatic int rand_exp();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 40)) - 20;
        return int'($urandom_range(0, 8)) - 4;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [OW-1:0] act;
        logic [OW-1:0] expv;
        forever begin
            @(negedge clk_sys);
            if (!rst_sys_n) continue;
            act = {next_sync_o, block_sync_o, k1_o, data_real_o, data_imag_o, data_exp_o};
            n_cmp++;
            if (data_val_o) begin
                if (cont_mode) cont_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got %h, required no valid output", act);
                end else begin
                    expv = exp_q.pop_front();
                    if (act !== expv) begin
                        n_err++;
                        $display("FAIL out: got %h (ns,bs,k1,re,im,exp), required %h", act, expv);
                    end
                end
            end else begin
                if ({next_sync_o, block_sync_o, data_real_o, data_imag_o, data_exp_o} !== '0) begin
                    n_err++;
                    $display("FAIL idle_zero: got %h while data_val_o=0, required 0", act);
                end
                if (cont_mode && cont_seen && exp_q.size() > 0) begin
                    n_err++;
                    $display("FAIL continuous: data_val_o=0 with %0d outputs pending, required 1",
                             exp_q.size());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        @(posedge clk_sys);
        #1;
        data_val_i   = 1'b0;
        stage_sync_i = 1'b0;
        block_sync_i = 1'b0;
    endtask

    // kind: 0 constant, 1 random, 2 exponent align, 3 overflow, 4 replay previous frame
    task automatic drive_frame(input int d, input int ldn, input bit bsync, input int kind,
                               input bit gaps, input int stop_at);
        logic [OW-1:0] dif_q[$];
        int cyc;
        int a;
        cyc = 0;
        if (kind != 4) begin
            for (int j = 0; j < 2 * d; j++) begin
                case (kind)
                    0: begin fr_re[j] = 100; fr_im[j] = -50; fr_e[j] = 0; end
                    2: begin fr_re[j] = 1000; fr_im[j] = 0; fr_e[j] = (j < d) ? 2 : 0; end
                    3: begin fr_re[j] = MAXP; fr_im[j] = 0; fr_e[j] = 3; end
                    default: begin
                        fr_re[j] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
                        fr_im[j] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
                        fr_e[j]  = rand_exp();
                    end
                endcase
            end
        end
        for (int j = 0; j < 2 * d && j < stop_at; j++) begin
            while (gaps && (cyc % 3 == 2)) begin
                @(posedge clk_sys);
                #1;
                data_val_i   = 1'b0;
                stage_sync_i = 1'b0;
                block_sync_i = 1'b0;
                data_real_i  = W'($urandom);
                data_imag_i  = W'($urandom);
                data_exp_i   = EW'($urandom);
                ldn_rg_i     = 4'($urandom_range(0, 15));
                cyc++;
            end
            @(posedge clk_sys);
            #1;
            data_val_i   = 1'b1;
            stage_sync_i = (j == 0);
            block_sync_i = (j == 0) && bsync;
            ldn_rg_i     = (j == 0) ? 4'(ldn) : 4'($urandom_range(0, 15));
            data_real_i  = W'(fr_re[j]);
            data_imag_i  = W'(fr_im[j]);
            data_exp_i   = EW'(fr_e[j]);
            cyc++;
            if (j >= d) begin
                a = j - d;
                exp_q.push_back(ref_bf(fr_re[a], fr_im[a], fr_e[a], fr_re[j], fr_im[j], fr_e[j],
                                       1'b0, 1'b0, j == d, (j == d) && bsync));
                dif_q.push_back(ref_bf(fr_re[a], fr_im[a], fr_e[a], fr_re[j], fr_im[j], fr_e[j],
                                       1'b1, 1'b1, 1'b0, 1'b0));
            end
            if (j == 2 * d - 1)
                while (dif_q.size() > 0) exp_q.push_back(dif_q.pop_front());
        end
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk_sys);
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL %s: %0d outputs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk_sys);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk_sys);
        chk("rst_val", data_val_o, 0);
        chk("rst_re", data_real_o, 0);
        chk("rst_im", data_imag_o, 0);
        chk("rst_exp", data_exp_o, 0);
        chk("rst_k1", k1_o, 0);
        chk("rst_next_sync", next_sync_o, 0);
        chk("rst_block_sync", block_sync_o, 0);
        #3 rst_sys_n = 1'b1;

        // 2048-pt constant frame, then autonomous drain
        drive_frame(256, 11, 1'b1, 0, 1'b0, 1 << 30);
        drive_idle();
        wait_empty("const_frame");

        drive_frame(128, 10, 1'b0, 2, 1'b0, 1 << 30);
        drive_idle();
        wait_empty("exp_align");

        drive_frame(128, 10, 1'b0, 3, 1'b0, 1 << 30);
        drive_idle();
        wait_empty("overflow");

        // back-to-back 1024-pt frames: diffs of frame 1 ride on the fill of frame 2
        cont_mode = 1'b1;
        drive_frame(128, 10, 1'b1, 1, 1'b0, 1 << 30);
        drive_frame(128, 10, 1'b0, 1, 1'b0, 1 << 30);
        drive_idle();
        wait_empty("back_to_back");
        cont_mode = 1'b0;
        cont_seen = 1'b0;

        // same random frame without and with input gaps
        drive_frame(128, 10, 1'b0, 1, 1'b0, 1 << 30);
        drive_idle();
        wait_empty("gapfree");
        drive_frame(128, 10, 1'b0, 4, 1'b1, 1 << 30);
        drive_idle();
        wait_empty("gapped");

        // unsupported ldn value falls back to D = 256
        drive_frame(256, 5, 1'b1, 1, 1'b1, 1 << 30);
        drive_idle();
        wait_empty("ldn_default");

        // reset in the middle of the sum half
        drive_frame(128, 10, 1'b0, 1, 1'b0, 128 + 20);
        #2;
        rst_sys_n  = 1'b0;
        data_val_i = 1'b0;
        stage_sync_i = 1'b0;
        #1;
        chk("midrst_val", data_val_o, 0);
        chk("midrst_re", data_real_o, 0);
        chk("midrst_im", data_imag_o, 0);
        chk("midrst_exp", data_exp_o, 0);
        chk("midrst_k1", k1_o, 0);
        exp_q.delete();
        repeat (2) @(posedge clk_sys);
        #3 rst_sys_n = 1'b1;
        // valid samples without stage_sync must not produce output
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_sys);
            #1;
            data_val_i  = 1'b1;
            data_real_i = W'($urandom);
            data_exp_i  = EW'($urandom_range(0, 3));
        end
        drive_frame(128, 10, 1'b1, 1, 1'b0, 1 << 30);
        drive_idle();
        wait_empty("after_reset");

        repeat (5) @(posedge clk_sys);
        chk("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
